// File: rtl/morse_trainer_controller.sv
// morse_trainer_controller: round sequencer for the Morse trainer.
// Picks pseudo-random target letters A-Z, clears the decode path before
// each attempt, grades a decoded letter or an inactivity timeout, and
// keeps the score for one round of ROUND_LEN attempts.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   start                begin a round (honoured in IDLE or DONE)
//   button               raw key level, activity indicator for timeout
//   letter_done          decoder letter-complete level (edge-detected)
//   ascii_char           decoded character, valid with letter_done
//   target_char          current target letter, 0 when idle/done
//   decoder_clear        one-cycle reset pulse for the decode path
//   result_valid         one-cycle pulse per graded attempt
//   result_correct       last grade was correct (held)
//   result_timeout       last attempt timed out (held)
//   correct_count        correct attempts this round
//   attempt_count        graded attempts this round
//   round_done           high while the round is finished
//   streak, best_streak  run of correct answers (optional feature)
// Optional feature macro: MORSE_TRAINER_STREAK_EN enables the streak
// and best_streak tracking; when undefined both outputs are tied to 0.
module morse_trainer_controller #(
   parameter int unsigned ROUND_LEN     = 10,
   parameter int unsigned TIMEOUT_TICKS = 100,
   parameter int unsigned RESULT_HOLD   = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       button,
   input  logic       letter_done,
   input  logic [7:0] ascii_char,
   output logic [7:0] target_char,
   output logic       decoder_clear,
   output logic       result_valid,
   output logic       result_correct,
   output logic       result_timeout,
   output logic [7:0] correct_count,
   output logic [7:0] attempt_count,
   output logic       round_done,
   output logic [7:0] streak,
   output logic [7:0] best_streak
);

   typedef enum logic [2:0] {
      IDLE, PICK, WAIT, CHECK, SHOW, DONE
   } state_t;

   localparam logic [15:0] T_LAST = 16'(TIMEOUT_TICKS - 1);
   localparam logic [7:0]  H_LAST = 8'(RESULT_HOLD - 1);
   localparam logic [7:0]  R_LEN  = 8'(ROUND_LEN);

   state_t      state;
   logic [7:0]  lfsr;
   logic        ld_q;
   logic [15:0] tcnt;
   logic [7:0]  hold;
   logic [7:0]  cap;
   logic        to_q;

   logic        rise;
   logic        fb;
   logic        hit;
   logic [4:0]  v;
   logic [4:0]  idx;

   assign rise = letter_done & ~ld_q;
   assign fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign v    = lfsr[4:0];
   // Fold 26..31 back onto 0..5 so every code maps to A-Z.
   assign idx  = (v >= 5'd26) ? v - 5'd26 : v;
   assign hit  = ~to_q & (cap == target_char);

`ifdef MORSE_TRAINER_STREAK_EN
   logic [7:0] s_inc;
   assign s_inc = streak + 8'd1;
`else
   assign streak      = '0;
   assign best_streak = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         lfsr           <= 8'hA5;
         ld_q           <= 1'b0;
         tcnt           <= '0;
         hold           <= '0;
         cap            <= '0;
         to_q           <= 1'b0;
         target_char    <= '0;
         decoder_clear  <= 1'b0;
         result_valid   <= 1'b0;
         result_correct <= 1'b0;
         result_timeout <= 1'b0;
         correct_count  <= '0;
         attempt_count  <= '0;
         round_done     <= 1'b0;
`ifdef MORSE_TRAINER_STREAK_EN
         streak         <= '0;
         best_streak    <= '0;
`endif
      end else begin
         // Free-running so the user's timing randomises targets.
         lfsr          <= {lfsr[6:0], fb};
         ld_q          <= letter_done;
         decoder_clear <= 1'b0;
         result_valid  <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= PICK;
                  correct_count  <= '0;
                  attempt_count  <= '0;
                  result_correct <= 1'b0;
                  result_timeout <= 1'b0;
                  round_done     <= 1'b0;
`ifdef MORSE_TRAINER_STREAK_EN
                  streak         <= '0;
                  best_streak    <= '0;
`endif
               end
            end
            PICK: begin
               target_char   <= 8'h41 + {3'b000, idx};
               decoder_clear <= 1'b1;
               tcnt          <= '0;
               state         <= WAIT;
            end
            WAIT: begin
               // A letter beats a timeout landing in the same cycle.
               if (rise) begin
                  cap   <= ascii_char;
                  to_q  <= 1'b0;
                  state <= CHECK;
               end else if (button) begin
                  tcnt <= '0;
               end else if (tcnt == T_LAST) begin
                  to_q  <= 1'b1;
                  state <= CHECK;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            CHECK: begin
               result_valid   <= 1'b1;
               result_correct <= hit;
               result_timeout <= to_q;
               attempt_count  <= attempt_count + 8'd1;
               if (hit) correct_count <= correct_count + 8'd1;
`ifdef MORSE_TRAINER_STREAK_EN
               if (hit) begin
                  streak <= s_inc;
                  if (s_inc > best_streak) best_streak <= s_inc;
               end else begin
                  streak <= '0;
               end
`endif
               hold  <= '0;
               state <= SHOW;
            end
            SHOW: begin
               if (hold == H_LAST) begin
                  if (attempt_count == R_LEN) begin
                     state       <= DONE;
                     round_done  <= 1'b1;
                     target_char <= '0;
                  end else begin
                     state <= PICK;
                  end
               end else begin
                  hold <= hold + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_trainer_controller.sv
// tb_morse_trainer_controller: directed bench with a behavioural
// round model checked every cycle plus hand-computed literal checks.
module tb_morse_trainer_controller;

   localparam int RL = 3;
   localparam int TO = 5;
   localparam int RH = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       button;
   logic       letter_done;
   logic [7:0] ascii_char;
   logic [7:0] target_char;
   logic       decoder_clear;
   logic       result_valid;
   logic       result_correct;
   logic       result_timeout;
   logic [7:0] correct_count;
   logic [7:0] attempt_count;
   logic       round_done;
   logic [7:0] streak;
   logic [7:0] best_streak;

   int checks = 0;
   int errors = 0;
   bit mon_on = 1'b0;

   morse_trainer_controller #(
      .ROUND_LEN(RL),
      .TIMEOUT_TICKS(TO),
      .RESULT_HOLD(RH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .button(button),
      .letter_done(letter_done),
      .ascii_char(ascii_char),
      .target_char(target_char),
      .decoder_clear(decoder_clear),
      .result_valid(result_valid),
      .result_correct(result_correct),
      .result_timeout(result_timeout),
      .correct_count(correct_count),
      .attempt_count(attempt_count),
      .round_done(round_done),
      .streak(streak),
      .best_streak(best_streak)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_PICK, M_WAIT, M_GRADE, M_SHOW, M_DONE} mode_t;

   mode_t      m_mode;
   logic [7:0] m_lfsr;
   logic       m_ld;
   int         idle_run;
   int         shown;
   logic [7:0] got;
   bit         timed;
   logic [7:0] e_target;
   bit         e_clear, e_valid, e_corr, e_to, e_done;
   int         e_cc, e_ac, e_str, e_best;

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], ^(x & 8'hB8)};
   endfunction

   function automatic logic [7:0] letter_of(input logic [7:0] x);
      int n;
      n = int'(x) % 32;
      if (n >= 26) n = n - 26;
      return 8'(65 + n);
   endfunction

   always @(posedge clock) begin
      bit rise_m;
      bit ok;
      rise_m = letter_done && !m_ld;
      m_ld   = letter_done;
      if (reset) begin
         m_mode = M_IDLE; m_lfsr = 8'hA5; m_ld = 1'b0;
         idle_run = 0; shown = 0; got = '0; timed = 0;
         e_target = '0; e_clear = 0; e_valid = 0; e_corr = 0;
         e_to = 0; e_done = 0; e_cc = 0; e_ac = 0;
         e_str = 0; e_best = 0;
      end else begin
         e_clear = 0;
         e_valid = 0;
         case (m_mode)
            M_IDLE, M_DONE: if (start) begin
               m_mode = M_PICK;
               e_cc = 0; e_ac = 0; e_corr = 0; e_to = 0;
               e_str = 0; e_best = 0; e_done = 0;
            end
            M_PICK: begin
               e_target = letter_of(m_lfsr);
               e_clear  = 1;
               idle_run = 0;
               m_mode   = M_WAIT;
            end
            M_WAIT: begin
               if (rise_m) begin
                  got = ascii_char; timed = 0; m_mode = M_GRADE;
               end else if (button) begin
                  idle_run = 0;
               end else begin
                  idle_run++;
                  if (idle_run == TO) begin
                     timed = 1; m_mode = M_GRADE;
                  end
               end
            end
            M_GRADE: begin
               ok = !timed && (got == e_target);
               e_valid = 1; e_corr = ok; e_to = timed;
               e_ac++;
               if (ok) e_cc++;
`ifdef MORSE_TRAINER_STREAK_EN
               if (ok) begin
                  e_str++;
                  if (e_str > e_best) e_best = e_str;
               end else e_str = 0;
`endif
               shown = 0;
               m_mode = M_SHOW;
            end
            M_SHOW: begin
               shown++;
               if (shown == RH) begin
                  if (e_ac == RL) begin
                     m_mode = M_DONE; e_done = 1; e_target = '0;
                  end else m_mode = M_PICK;
               end
            end
            default: m_mode = M_IDLE;
         endcase
         m_lfsr = lfsr_next(m_lfsr);
      end
   end

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (mon_on) begin
         chk("target", target_char, e_target);
         chk("clear", {7'd0, decoder_clear}, {7'd0, e_clear});
         chk("valid", {7'd0, result_valid}, {7'd0, e_valid});
         chk("correct", {7'd0, result_correct}, {7'd0, e_corr});
         chk("timeout", {7'd0, result_timeout}, {7'd0, e_to});
         chk("done", {7'd0, round_done}, {7'd0, e_done});
         chk("ccount", correct_count, 8'(e_cc));
         chk("acount", attempt_count, 8'(e_ac));
         chk("streak", streak, 8'(e_str));
         chk("best", best_streak, 8'(e_best));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_letter(input logic [7:0] ch);
      letter_done = 1'b1;
      ascii_char  = ch;
      tick();
      letter_done = 1'b0;
      ascii_char  = 8'h00;
   endtask

   task automatic wait_clear();
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (decoder_clear) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wait_clear got timeout want pulse t=%0t", $time);
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (round_done) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wait_done got timeout want round_done t=%0t", $time);
      end
   endtask

   localparam logic [7:0] BEST3 =
`ifdef MORSE_TRAINER_STREAK_EN
      8'd3;
`else
      8'd0;
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got hang want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; button = 1'b0;
      letter_done = 1'b0; ascii_char = 8'h00;
      tick();
      mon_on = 1'b1;
      tick();
      tick();
      chk("rst_target", target_char, 8'h00);
      chk("rst_acount", attempt_count, 8'h00);
      chk("rst_done", {7'd0, round_done}, 8'h00);
      reset = 1'b0;
      // After 255 steps the LFSR is back at A5 during PICK -> 'F'.
      repeat (254) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("lit_first_target", target_char, 8'h46);
      chk("lit_clear_hi", {7'd0, decoder_clear}, 8'h01);
      send_letter(8'h46);
      chk("lit_clear_lo", {7'd0, decoder_clear}, 8'h00);
      tick();
      chk("lit_match_valid", {7'd0, result_valid}, 8'h01);
      chk("lit_match_ok", {7'd0, result_correct}, 8'h01);
      chk("lit_match_cc", correct_count, 8'd1);
      chk("lit_match_ac", attempt_count, 8'd1);
      // Letter rise during SHOW must be ignored.
      tick();
      letter_done = 1'b1; ascii_char = 8'h48;
      tick();
      letter_done = 1'b0; ascii_char = 8'h00;
      wait_clear();
      chk("lit_second_target", target_char, 8'h48);
      // Wrong letter.
      send_letter(8'h45);
      tick();
      chk("lit_wrong_ok", {7'd0, result_correct}, 8'h00);
      chk("lit_wrong_cc", correct_count, 8'd1);
      chk("lit_wrong_ac", attempt_count, 8'd2);
      wait_clear();
      // Timeout with a button pulse in wait cycle 3.
      tick(); tick();
      button = 1'b1;
      tick();
      button = 1'b0;
      repeat (5) tick();
      tick();
      chk("lit_to_valid", {7'd0, result_valid}, 8'h01);
      chk("lit_to_flag", {7'd0, result_timeout}, 8'h01);
      chk("lit_to_ac", attempt_count, 8'd3);
      wait_done();
      chk("lit_done_target", target_char, 8'h00);
      chk("lit_done_cc", correct_count, 8'd1);
      // Round 2: letter lands in the timeout terminal cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lit_restart_ac", attempt_count, 8'd0);
      chk("lit_restart_done", {7'd0, round_done}, 8'h00);
      wait_clear();
      repeat (4) tick();
      send_letter(e_target);
      tick();
      chk("lit_term_valid", {7'd0, result_valid}, 8'h01);
      chk("lit_term_to", {7'd0, result_timeout}, 8'h00);
      chk("lit_term_ok", {7'd0, result_correct}, 8'h01);
      for (int a = 0; a < 2; a++) begin
         wait_clear();
         send_letter(e_target);
         tick();
      end
      wait_done();
      chk("lit_r2_cc", correct_count, 8'd3);
      chk("lit_r2_best", best_streak, BEST3);
      // Round 3: reset while in SHOW.
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_clear();
      send_letter(e_target);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("lit_mid_rst_ac", attempt_count, 8'd0);
      chk("lit_mid_rst_cc", correct_count, 8'd0);
      chk("lit_mid_rst_target", target_char, 8'h00);
      chk("lit_mid_rst_ok", {7'd0, result_correct}, 8'h00);
      reset = 1'b0;
      repeat (3) tick();
      chk("lit_idle_target", target_char, 8'h00);
      chk("lit_idle_clear", {7'd0, decoder_clear}, 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
